// File: rtl/conn_req_ctrl_pkg.sv
// Shared types for the connection request sequencer: state encoding, widths, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package conn_req_ctrl_pkg;

   // Default width of the timeout counter and of every period parameter
   localparam int CNT_W_DEF = 16;
   // Width of the retry index
   localparam int RETRY_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_BACKOFF   = 3'd3,
      ST_CONNECTED = 3'd4,
      ST_KA_WAIT   = 3'd5,
      ST_FAIL      = 3'd6
   } state_e;

   // A link counts as up while connected or while a keep-alive probe is outstanding
   function automatic logic is_linked(input state_e s);
      return (s == ST_CONNECTED) || (s == ST_KA_WAIT);
   endfunction

endpackage

// File: rtl/conn_req_ctrl_timer.sv
// Loadable down-counter shared by the ack, backoff and keep-alive phases.
// Latency: a load of N raises o_expire N cycles after the load cycle.
// Backpressure: none; clear beats load, load beats decrement, zero holds.
module conn_timer
   import conn_req_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             i_sys_clk,
   input  logic             i_rstn,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, runtime load, or count down and rest at zero
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_load) begin
         cnt_d = i_load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge i_sys_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry is the cycle the count sits at 1 (it reaches 0 on the next edge)
   assign o_expire = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/conn_req_ctrl.sv
// Connection establishment / keep-alive sequencer with exponential-backoff retries.
// Latency: o_connect_req two cycles after i_open is sampled; all outputs registered.
// Backpressure: none; pulse handshake with the peer, i_close aborts from any state.
module conn_req_ctrl
   import conn_req_ctrl_pkg::*;
#(
   parameter int               CNT_W            = CNT_W_DEF,
   parameter logic [CNT_W-1:0] ACK_TIMEOUT      = 16'h34BC,
   parameter logic [CNT_W-1:0] BACKOFF_BASE     = 16'h0100,
   parameter logic [CNT_W-1:0] KEEPALIVE_PERIOD = 16'hFFFF,
   parameter int               MAX_RETRY        = 3
)(
   input  logic               i_sys_clk,
   input  logic               i_rstn,
   input  logic               i_open,
   input  logic               i_close,
   input  logic               i_ack,
   input  logic               i_nack,
   input  logic               i_rx_vld,
   output logic               o_connect_req,
   output logic               o_keepalive_req,
   output logic               o_connected,
   output logic               o_fail,
   output logic [RETRY_W-1:0] o_retry_cnt
);

   localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);
   // Wide enough that BACKOFF_BASE shifted by any retry index never loses bits
   localparam int SHW = CNT_W + (1 << RETRY_W);

   state_e             state_q, state_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               creq_q, creq_d;
   logic               ka_q, ka_d;
   logic               conn_q, conn_d;
   logic               fail_q, fail_d;

   logic               tmr_clr;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_load_val;
   logic               tmr_expire;

   logic [SHW-1:0]     bo_wide;
   logic [CNT_W-1:0]   bo_val;

   conn_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_sys_clk  (i_sys_clk),
      .i_rstn     (i_rstn),
      .i_clr      (tmr_clr),
      .i_load     (tmr_load),
      .i_load_val (tmr_load_val),
      .o_expire   (tmr_expire)
   );

   // Backoff for the current retry index, saturating to all-ones on overflow
   always_comb begin
      bo_wide = {{(SHW-CNT_W){1'b0}}, BACKOFF_BASE} << retry_q;
      bo_val  = (|bo_wide[SHW-1:CNT_W]) ? '1 : bo_wide[CNT_W-1:0];
   end

   // State, retry index and registered outputs
   always_ff @(posedge i_sys_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
         creq_q  <= 1'b0;
         ka_q    <= 1'b0;
         conn_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         creq_q  <= creq_d;
         ka_q    <= ka_d;
         conn_q  <= conn_d;
         fail_q  <= fail_d;
      end
   end

   // Next state, retry index and timer control; close > ack > rx > nack > expiry
   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      tmr_clr      = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      if (i_close) begin
         state_d = ST_IDLE;
         tmr_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAIL: begin
               if (i_open) begin
                  state_d = ST_REQ;
                  retry_d = '0;
               end
            end
            ST_REQ: begin
               tmr_load     = 1'b1;
               tmr_load_val = ACK_TIMEOUT;
               state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (i_ack) begin
                  state_d      = ST_CONNECTED;
                  retry_d      = '0;
                  tmr_load     = 1'b1;
                  tmr_load_val = KEEPALIVE_PERIOD;
               end else if (i_nack || tmr_expire) begin
                  if (retry_q == MAX_R) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d      = ST_BACKOFF;
                     retry_d      = retry_q + 1'b1;
                     tmr_load     = 1'b1;
                     tmr_load_val = bo_val;
                  end
               end
            end
            ST_BACKOFF: begin
               if (tmr_expire) begin
                  state_d = ST_REQ;
               end
            end
            ST_CONNECTED: begin
               if (i_rx_vld) begin
                  tmr_load     = 1'b1;
                  tmr_load_val = KEEPALIVE_PERIOD;
               end else if (tmr_expire) begin
                  state_d      = ST_KA_WAIT;
                  tmr_load     = 1'b1;
                  tmr_load_val = ACK_TIMEOUT;
               end
            end
            ST_KA_WAIT: begin
               if (i_ack || i_rx_vld) begin
                  state_d      = ST_CONNECTED;
                  tmr_load     = 1'b1;
                  tmr_load_val = KEEPALIVE_PERIOD;
               end else if (tmr_expire) begin
                  state_d = ST_REQ;
                  retry_d = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               tmr_clr = 1'b1;
            end
         endcase
      end
   end

   // Output values for the next cycle: pulses mark transitions, levels follow next state
   always_comb begin
      creq_d = !i_close && (state_q == ST_REQ);
      ka_d   = !i_close && (state_q == ST_CONNECTED) && (state_d == ST_KA_WAIT);
      conn_d = is_linked(state_d);
      fail_d = (state_d == ST_FAIL);
   end

   assign o_connect_req   = creq_q;
   assign o_keepalive_req = ka_q;
   assign o_connected     = conn_q;
   assign o_fail          = fail_q;
   assign o_retry_cnt     = retry_q;

endmodule

// File: tb/tb_conn_req_ctrl.sv
// Directed bench for conn_req_ctrl with a deadline-based reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_conn_req_ctrl;

   localparam int ACK  = 10;
   localparam int BO   = 4;
   localparam int KA   = 20;
   localparam int MAXR = 2;

   logic       clk = 1'b0;
   logic       rstn;
   logic       i_open, i_close, i_ack, i_nack, i_rx_vld;
   logic       o_connect_req, o_keepalive_req, o_connected, o_fail;
   logic [3:0] o_retry_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int req_seen[$];
   int ka_seen[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conn_req_ctrl #(
      .CNT_W            (16),
      .ACK_TIMEOUT      (16'd10),
      .BACKOFF_BASE     (16'd4),
      .KEEPALIVE_PERIOD (16'd20),
      .MAX_RETRY        (2)
   ) dut (
      .i_sys_clk       (clk),
      .i_rstn          (rstn),
      .i_open          (i_open),
      .i_close         (i_close),
      .i_ack           (i_ack),
      .i_nack          (i_nack),
      .i_rx_vld        (i_rx_vld),
      .o_connect_req   (o_connect_req),
      .o_keepalive_req (o_keepalive_req),
      .o_connected     (o_connected),
      .o_fail          (o_fail),
      .o_retry_cnt     (o_retry_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Timing is tracked as an absolute deadline cycle rather than a counter.
   typedef enum int {M_IDLE, M_REQ, M_WAIT, M_BACK, M_CONN, M_KA, M_FAIL} mode_e;
   mode_e m        = M_IDLE;
   int    retry    = 0;
   int    deadline = -1;
   bit    e_creq = 0, e_ka = 0, e_conn = 0, e_fail = 0;

   function automatic int bo_len(input int r);
      longint v = BO;
      for (int k = 0; k < r; k++) v = v * 2;
      return (v > 65535) ? 65535 : int'(v);
   endfunction

   function automatic int arm(input int now, input int n);
      return (n == 0) ? -1 : now + n;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            m = M_IDLE; retry = 0; deadline = -1;
            e_creq = 0; e_ka = 0;
         end else begin
            bit ex;
            ex = (deadline >= 0) && (cyc == deadline);
            e_creq = 0; e_ka = 0;
            if (i_close) begin
               m = M_IDLE; deadline = -1;
            end else begin
               case (m)
                  M_IDLE, M_FAIL: if (i_open) begin m = M_REQ; retry = 0; end
                  M_REQ: begin e_creq = 1; deadline = arm(cyc, ACK); m = M_WAIT; end
                  M_WAIT: begin
                     if (i_ack) begin m = M_CONN; retry = 0; deadline = arm(cyc, KA); end
                     else if (i_nack || ex) begin
                        if (retry == MAXR) m = M_FAIL;
                        else begin deadline = arm(cyc, bo_len(retry)); retry++; m = M_BACK; end
                     end
                  end
                  M_BACK: if (ex) m = M_REQ;
                  M_CONN: begin
                     if (i_rx_vld) deadline = arm(cyc, KA);
                     else if (ex) begin e_ka = 1; deadline = arm(cyc, ACK); m = M_KA; end
                  end
                  M_KA: begin
                     if (i_ack || i_rx_vld) begin m = M_CONN; deadline = arm(cyc, KA); end
                     else if (ex) begin m = M_REQ; retry = 0; end
                  end
                  default: m = M_IDLE;
               endcase
            end
         end
         e_conn = (m == M_CONN) || (m == M_KA);
         e_fail = (m == M_FAIL);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cyc > 0) begin
         if (!rstn) begin
            chk("rst_creq", o_connect_req, 0);
            chk("rst_ka", o_keepalive_req, 0);
            chk("rst_conn", o_connected, 0);
            chk("rst_fail", o_fail, 0);
            chk("rst_retry", o_retry_cnt, 0);
         end else begin
            chk("m_creq", o_connect_req, e_creq);
            chk("m_ka", o_keepalive_req, e_ka);
            chk("m_conn", o_connected, e_conn);
            chk("m_fail", o_fail, e_fail);
            chk("m_retry", o_retry_cnt, retry);
         end
      end
      if (o_connect_req === 1'b1) req_seen.push_back(cyc);
      if (o_keepalive_req === 1'b1) ka_seen.push_back(cyc);
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         i_open = 0; i_close = 0; i_ack = 0; i_nack = 0; i_rx_vld = 0;
      end
   endtask

   task automatic goto(input int c);
      int guard = 0;
      while (cyc < c && guard < 5000) begin
         step();
         guard++;
      end
      if (cyc != c) chk("goto_bound", cyc, c);
   endtask

   function automatic int rel(input int q[$], input int idx, input int base);
      return (q.size() > idx) ? q[idx] - base : -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, c0, last, l2;
      rstn = 0; i_open = 0; i_close = 0; i_ack = 0; i_nack = 0; i_rx_vld = 0;
      step(3);
      rstn = 1;
      step();
      chk("reset_conn", o_connected, 0);
      chk("reset_fail", o_fail, 0);
      chk("reset_retry", o_retry_cnt, 0);

      // open, ack at cycle 5
      t0 = cyc; req_seen.delete();
      i_open = 1; step();
      goto(t0 + 5);
      chk("t1_conn_pre", o_connected, 0);
      i_ack = 1; step();
      chk("t1_conn", o_connected, 1);
      chk("t1_req_n", req_seen.size(), 1);
      chk("t1_req_at", rel(req_seen, 0, t0), 2);
      chk("t1_retry", o_retry_cnt, 0);
      i_close = 1; step();
      chk("close_conn", o_connected, 0);

      // never acked: three requests then FAIL
      t0 = cyc; req_seen.delete();
      i_open = 1; step();
      goto(t0 + 45);
      chk("t2_fail_pre", o_fail, 0);
      goto(t0 + 46);
      chk("t2_fail", o_fail, 1);
      goto(t0 + 50);
      chk("t2_req_n", req_seen.size(), 3);
      chk("t2_req0", rel(req_seen, 0, t0), 2);
      chk("t2_req1", rel(req_seen, 1, t0), 17);
      chk("t2_req2", rel(req_seen, 2, t0), 36);
      chk("t2_retry", o_retry_cnt, 2);

      // nack three cycles after each request
      t0 = cyc; req_seen.delete();
      i_open = 1; step();
      chk("t3_fail_clr", o_fail, 0);
      goto(t0 + 5);  i_nack = 1; step();
      goto(t0 + 14); i_nack = 1; step();
      goto(t0 + 27); i_nack = 1; step();
      chk("t3_fail", o_fail, 1);
      chk("t3_retry", o_retry_cnt, 2);
      chk("t3_req1", rel(req_seen, 1, t0), 11);
      chk("t3_req2", rel(req_seen, 2, t0), 24);
      t1 = cyc;
      i_open = 1; step();
      chk("t3_reopen_fail", o_fail, 0);
      goto(t1 + 2);
      chk("t3_reopen_req", o_connect_req, 1);
      goto(t1 + 4); i_ack = 1; step();
      chk("t3_conn", o_connected, 1);

      // periodic RX keeps the link quiet, then a probe and an RX answer
      c0 = cyc; ka_seen.delete();
      for (int k = 0; k < 14; k++) begin
         goto(c0 + 15 * k); i_rx_vld = 1; step();
      end
      last = c0 + 195;
      chk("t4_no_probe", ka_seen.size(), 0);
      goto(last + 20);
      chk("t4_probe_pre", o_keepalive_req, 0);
      goto(last + 21);
      chk("t4_probe", o_keepalive_req, 1);
      goto(last + 24); i_rx_vld = 1; step();
      chk("t4_conn", o_connected, 1);
      chk("t4_probe_n", ka_seen.size(), 1);

      // unanswered probe: reconnect
      l2 = last + 24; req_seen.delete();
      goto(l2 + 30);
      chk("t5_conn_pre", o_connected, 1);
      goto(l2 + 31);
      chk("t5_conn_drop", o_connected, 0);
      chk("t5_req_pre", o_connect_req, 0);
      goto(l2 + 32);
      chk("t5_req", o_connect_req, 1);
      chk("t5_retry", o_retry_cnt, 0);

      // close with ack in WAIT_ACK
      goto(l2 + 33); i_close = 1; i_ack = 1; step();
      chk("t6_close_conn", o_connected, 0);
      step(3);
      chk("t6_idle_conn", o_connected, 0);

      // ack with nack on the expiry cycle is an ack
      t0 = cyc;
      i_open = 1; step();
      goto(t0 + 11); i_ack = 1; i_nack = 1; step();
      chk("t6_ack_exp_conn", o_connected, 1);
      chk("t6_ack_exp_retry", o_retry_cnt, 0);
      i_close = 1; step();

      // reset while backing off
      t0 = cyc;
      i_open = 1; step();
      goto(t0 + 5); i_nack = 1; step();
      goto(t0 + 7);
      chk("t7_retry_pre", o_retry_cnt, 1);
      rstn = 0;
      #1;
      chk("t7_rst_retry", o_retry_cnt, 0);
      chk("t7_rst_conn", o_connected, 0);
      chk("t7_rst_fail", o_fail, 0);
      chk("t7_rst_creq", o_connect_req, 0);
      step(2);
      rstn = 1; req_seen.delete(); ka_seen.delete();
      step(10);
      chk("t7_no_req", req_seen.size(), 0);
      chk("t7_no_ka", ka_seen.size(), 0);
      chk("t7_retry", o_retry_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
